// File: rtl/kovacs_sequencer.sv
// Multi-phase protocol sequencer: steps through up to N_PHASES programmable phases
// (pass / zero / constant / hold) between the ADC stream and the DAC output.
module kovacs_sequencer #(
    parameter int unsigned DATA_IN_W  = 16,
    parameter int unsigned DATA_OUT_W = 14,
    parameter int unsigned N_PHASES   = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned PH_W       = $clog2(N_PHASES)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           enable_i,
    input  logic [DATA_IN_W-1:0]           data_i,
    input  logic [N_PHASES*CNT_W-1:0]      dur_i,
    input  logic [N_PHASES*2-1:0]          mode_i,
    input  logic [N_PHASES*DATA_OUT_W-1:0] level_i,
    input  logic [PH_W-1:0]                last_phase_i,
    output logic [DATA_OUT_W-1:0]          data_o,
    output logic [DATA_OUT_W-1:0]          indicator_o,
    output logic [PH_W-1:0]                phase_o,
    output logic                           cycle_o,
    output logic [15:0]                    cycle_count_o
);

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_ZERO  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    localparam logic [DATA_OUT_W-1:0] IND_HI = {1'b0, {(DATA_OUT_W-1){1'b1}}};
    localparam logic [PH_W-1:0]       PH_MAX = PH_W'(N_PHASES-1);

    logic                  run_q,   run_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [CNT_W-1:0]      dur_q,   dur_d;
    mode_e                 mode_q,  mode_d;
    logic [DATA_OUT_W-1:0] level_q, level_d;
    logic [DATA_OUT_W-1:0] hold_q,  hold_d;
    logic [DATA_OUT_W-1:0] data_q,  data_d;
    logic [DATA_OUT_W-1:0] ind_q,   ind_d;
    logic [PH_W-1:0]       oph_q,   oph_d;
    logic                  cyc_q,   cyc_d;
    logic [15:0]           ccnt_q,  ccnt_d;

    logic [PH_W-1:0]       last_c;
    logic                  wrap_c;
    logic [PH_W-1:0]       next_ph_c;
    logic [PH_W-1:0]       load_ph_c;
    logic [DATA_OUT_W-1:0] sample_c;
    logic                  unused_data;

    // Low input bits fall below the DAC resolution and are intentionally dropped.
    assign unused_data = ^data_i;
    assign sample_c    = data_i[DATA_IN_W-1 -: DATA_OUT_W];

    // Clamp is only needed when the index width can encode phases that do not exist.
    if ((2 ** PH_W) > N_PHASES) begin : g_clamp
        assign last_c = (last_phase_i > PH_MAX) ? PH_MAX : last_phase_i;
    end else begin : g_noclamp
        assign last_c = last_phase_i;
    end

    // A phase index above the last one (last lowered mid-run) also wraps to 0.
    assign wrap_c    = (phase_q >= last_c);
    assign next_ph_c = wrap_c ? '0 : phase_q + PH_W'(1);
    assign load_ph_c = run_q ? next_ph_c : '0;

    always_comb begin
        run_d   = run_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        dur_d   = dur_q;
        mode_d  = mode_q;
        level_d = level_q;
        hold_d  = hold_q;
        data_d  = data_q;
        ind_d   = ind_q;
        oph_d   = oph_q;
        cyc_d   = 1'b0;
        ccnt_d  = ccnt_q;

        if (!enable_i) begin
            run_d   = 1'b0;
            cnt_d   = '0;
            phase_d = '0;
            data_d  = '0;
            ind_d   = '0;
            oph_d   = '0;
        end else if (!run_q) begin
            // First enabled edge: snapshot phase 0, outputs follow one edge later.
            run_d   = 1'b1;
            cnt_d   = '0;
            phase_d = '0;
            dur_d   = dur_i[32'(load_ph_c)*CNT_W +: CNT_W];
            mode_d  = mode_e'(mode_i[32'(load_ph_c)*2 +: 2]);
            level_d = level_i[32'(load_ph_c)*DATA_OUT_W +: DATA_OUT_W];
            data_d  = '0;
            ind_d   = '0;
            oph_d   = '0;
        end else begin
            oph_d = phase_q;
            ind_d = '0;
            case (mode_q)
                MODE_PASS: begin
                    data_d = sample_c;
                    hold_d = sample_c;
                    ind_d  = IND_HI;
                end
                MODE_ZERO:  data_d = '0;
                MODE_CONST: data_d = level_q;
                default:    data_d = hold_q;
            endcase

            if (cnt_q == dur_q) begin
                cnt_d   = '0;
                phase_d = next_ph_c;
                dur_d   = dur_i[32'(load_ph_c)*CNT_W +: CNT_W];
                mode_d  = mode_e'(mode_i[32'(load_ph_c)*2 +: 2]);
                level_d = level_i[32'(load_ph_c)*DATA_OUT_W +: DATA_OUT_W];
                if (wrap_c) begin
                    cyc_d  = 1'b1;
                    ccnt_d = ccnt_q + 16'd1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q   <= 1'b0;
            cnt_q   <= '0;
            phase_q <= '0;
            dur_q   <= '0;
            mode_q  <= MODE_PASS;
            level_q <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            ind_q   <= '0;
            oph_q   <= '0;
            cyc_q   <= 1'b0;
            ccnt_q  <= '0;
        end else begin
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            dur_q   <= dur_d;
            mode_q  <= mode_d;
            level_q <= level_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            ind_q   <= ind_d;
            oph_q   <= oph_d;
            cyc_q   <= cyc_d;
            ccnt_q  <= ccnt_d;
        end
    end

    assign data_o        = data_q;
    assign indicator_o   = ind_q;
    assign phase_o       = oph_q;
    assign cycle_o       = cyc_q;
    assign cycle_count_o = ccnt_q;

endmodule
